serial_subtractor_16bit: RTL
============================

Name: serial_subtractor_16bit

Overview:
Multi-cycle, bit-serial unsigned subtractor. Computes diff = a - b - borrow_in, which is the inverse operation of the 16-bit ripple adder datapath.
Processes BITS_PER_CYCLE bits per clock from LSB to MSB, with a registered borrow chain. Uses a start/busy/done handshake.
Sits beside the adder in the arithmetic unit and is shared by sequential datapaths that trade latency for area.

Parameters:
NUM_BITS, 16, operand and result width.
BITS_PER_CYCLE, 1, bits processed per RUN cycle. Must divide NUM_BITS; otherwise elaboration fails via $fatal.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
start  input  1  request. Sampled only in IDLE or DONE.
a  input  NUM_BITS  minuend. Sampled on the accepted start cycle.
b  input  NUM_BITS  subtrahend. Sampled on the accepted start cycle.
borrow_in  input  1  incoming borrow. Sampled on the accepted start cycle.
diff  output  NUM_BITS  registered result. Holds until the next result completes.
borrow_out  output  1  registered final borrow: 1 iff a < b + borrow_in (unsigned).
busy  output  1  high while in RUN.
done  output  1  single-cycle pulse when diff and borrow_out become valid.

Behaviour:
- Reset (n_rst=0, asynchronous):
  - state=IDLE.
  - diff=0, borrow_out=0, busy=0, done=0.
  - Internal shift registers, borrow flop and slice counter all cleared.
  - Reset asserted mid-RUN aborts the operation with no done pulse.
- Let N = NUM_BITS/BITS_PER_CYCLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 in cycle k: latch a, b and borrow_in into operand shift registers and the borrow flop, clear the counter, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1 for exactly N cycles (k+1 .. k+N).
  - Each cycle: subtract the low BITS_PER_CYCLE bits of a_sr and b_sr with the current borrow. Shift the result slice into the result register from the MSB side, shift the operands right by BITS_PER_CYCLE, update the borrow flop, increment the counter.
  - start is ignored; inputs may change freely.
  - On the last slice (counter = N-1): load diff and borrow_out from the completed result and final borrow, then go to DONE.
- DONE:
  - Lasts one cycle (k+N+1). done=1, busy=0.
  - start=1 in this cycle is accepted exactly as in IDLE (back-to-back ops, no bubble). Otherwise return to IDLE.
- Latency: start accepted at cycle k gives done at cycle k+N+1 (k+17 for the defaults).
- Arithmetic:
  - diff = (a - b - borrow_in) mod 2^NUM_BITS.
  - borrow_out = bit NUM_BITS of the (NUM_BITS+1)-bit unsigned difference.
  - No signed overflow flag.
- diff and borrow_out change only on the done edge; they stay stable through subsequent IDLE and RUN.
- Wrap-around: 0 - 0 - 1 gives diff = all ones, borrow_out = 1.

Decomposition:
- Package serial_sub_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, RUN, DONE};
  - localparams for N and the counter width ($clog2(N), minimum 1).
- One sub-module, sub_slice: combinational BITS_PER_CYCLE-bit subtract.
  - Inputs: x, y, bin. Outputs: d, bout.
  - Instanced once in the RUN datapath.
- The FSM, shift registers and counter live in the top module.

Test Plan:
1. Assert n_rst=0 in RUN cycle 5 after start (a=0x1234, b=0x0001) -> all outputs 0 immediately, no done pulse. After release, state is IDLE and busy=0.
2. a=0x0000, b=0x0001, borrow_in=0, start at cycle k -> busy high k+1..k+16, done only at k+17, diff=0xFFFF, borrow_out=1.
3. a=0xFFFA, b=0x0001 -> diff=0xFFF9, borrow_out=0. a=0xAAFF, b=0xFFAA -> diff=0xAB55, borrow_out=1. Outputs hold after done.
4. borrow_in=1 with a=0x0002, b=0x0001 -> diff=0x0000, borrow_out=0. borrow_in=1 with a=b=0x0000 -> diff=0xFFFF, borrow_out=1.
5. Start pulsed with new operands during RUN -> ignored, first result unchanged. Start held in the DONE cycle with a=0x0005, b=0x0003 -> second done exactly 17 cycles later with diff=0x0002, borrow_out=0.
6. BITS_PER_CYCLE=4 with a=0x8000, b=0x0001 -> done 5 cycles after start, diff=0x7FFF, borrow_out=0.

Source files
------------

// File: rtl/serial_subtractor_16bit_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Slice counter width; never narrower than one bit so N=1 still has a counter.
   function automatic int unsigned cnt_width(input int unsigned n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned NUM_BITS_DEF       = 16;
   localparam int unsigned BITS_PER_CYCLE_DEF = 1;
   localparam int unsigned N_DEF              = NUM_BITS_DEF / BITS_PER_CYCLE_DEF;
   localparam int unsigned CNT_W_DEF          = cnt_width(N_DEF);

endpackage

// File: rtl/serial_subtractor_16bit_sub_slice.sv
// Combinational W-bit subtract slice: {bout, d} = x - y - bin.
module sub_slice
   import serial_sub_pkg::*;
#(
   parameter int unsigned W = BITS_PER_CYCLE_DEF
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         bin,
   output logic [W-1:0] d,
   output logic         bout
);

   localparam int unsigned WP1 = W + 1;

   logic [W:0] w_full;

   // Zero-extended difference; the extra MSB is the borrow out.
   assign w_full = {1'b0, x} - {1'b0, y} - WP1'(bin);
   assign d      = w_full[W-1:0];
   assign bout   = w_full[W];

endmodule

// File: rtl/serial_subtractor_16bit.sv
// Multi-cycle bit-serial unsigned subtractor: diff = a - b - borrow_in,
// BITS_PER_CYCLE bits per clock, LSB first, with start/busy/done handshake.
module serial_subtractor_16bit
   import serial_sub_pkg::*;
#(
   parameter int unsigned NUM_BITS       = NUM_BITS_DEF,
   parameter int unsigned BITS_PER_CYCLE = BITS_PER_CYCLE_DEF
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   input  logic                borrow_in,
   output logic [NUM_BITS-1:0] diff,
   output logic                borrow_out,
   output logic                busy,
   output logic                done
);

   localparam int unsigned N     = NUM_BITS / BITS_PER_CYCLE;
   localparam int unsigned CNT_W = cnt_width(N);

   if ((BITS_PER_CYCLE == 0) || ((NUM_BITS % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
      $fatal(1, "BITS_PER_CYCLE must be nonzero and divide NUM_BITS");
   end

   state_t                    r_state;
   state_t                    w_next;
   logic                      w_accept;
   logic                      w_last;

   logic [NUM_BITS-1:0]       r_a_sr;
   logic [NUM_BITS-1:0]       r_b_sr;
   logic                      r_borrow;
   logic [CNT_W-1:0]          r_cnt;
   logic [NUM_BITS-1:0]       r_diff;
   logic                      r_borrow_out;
   logic                      r_busy;
   logic                      r_done;

   logic [BITS_PER_CYCLE-1:0] w_d;
   logic                      w_bout;
   logic [NUM_BITS-1:0]       w_res_next;

   sub_slice #(
      .W (BITS_PER_CYCLE)
   ) u_slice (
      .x    (r_a_sr[BITS_PER_CYCLE-1:0]),
      .y    (r_b_sr[BITS_PER_CYCLE-1:0]),
      .bin  (r_borrow),
      .d    (w_d),
      .bout (w_bout)
   );

   // Partial result: completed slices enter from the MSB side and drift down.
   if (N > 1) begin : g_acc
      logic [NUM_BITS-BITS_PER_CYCLE-1:0] r_acc;

      assign w_res_next = {w_d, r_acc};

      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            r_acc <= '0;
         end else if (w_accept) begin
            r_acc <= '0;
         end else if (r_state == RUN) begin
            r_acc <= w_res_next[NUM_BITS-1:BITS_PER_CYCLE];
         end
      end
   end else begin : g_single
      assign w_res_next = w_d;
   end

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; DONE accepts a new start just like IDLE.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_last   = 1'b0;
      unique case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = RUN;
            end else begin
               w_next   = IDLE;
            end
         end
         RUN: begin
            if (r_cnt == CNT_W'(N - 1)) begin
               w_last = 1'b1;
               w_next = DONE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Operand shifters, borrow chain, slice counter and result registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_a_sr       <= '0;
         r_b_sr       <= '0;
         r_borrow     <= 1'b0;
         r_cnt        <= '0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_busy <= (w_next == RUN);
         r_done <= (w_next == DONE);
         if (w_accept) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= borrow_in;
            r_cnt    <= '0;
         end else if (r_state == RUN) begin
            r_a_sr   <= r_a_sr >> BITS_PER_CYCLE;
            r_b_sr   <= r_b_sr >> BITS_PER_CYCLE;
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
               r_diff       <= w_res_next;
               r_borrow_out <= w_bout;
            end
         end
      end
   end

   assign diff       = r_diff;
   assign borrow_out = r_borrow_out;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule
